// File: rtl/serial_lt_comparator_if.sv
// Start/done handshake and result bus between the control unit and the bit-serial
// less-than comparator that sits beside the ALU.
interface serial_lt_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lt_mask;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, A, B, is_signed,
    input  busy, done, lt_mask, lt, eq, gt
  );

  modport slave (
    input  start, A, B, is_signed,
    output busy, done, lt_mask, lt, eq, gt
  );
endinterface : serial_lt_comparator_if

// File: rtl/serial_lt_comparator.sv
// Bit-serial magnitude comparator for slt/sltu: scans latched operands LSB-first,
// one bit per clock, and reports lt/eq/gt plus an all-ones/all-zeros less-than mask.
module serial_lt_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_lt_comparator_if.slave  cmp
);

  localparam int CW = $clog2(WIDTH);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  cnt_t             cnt_q;
  logic             lt_acc_q, lt_acc_d;
  logic             eq_acc_q, eq_acc_d;
  logic             done_q, done_d;
  logic             busy_d;
  logic             lt_q, eq_q, gt_q;
  logic [WIDTH-1:0] lt_mask_q;

  logic a_bit, b_bit, diff, signed_msb;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmp.start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done is registered on the DONE exit edge, so it is seen in the first IDLE cycle.
  always_comb begin
    busy_d = (state_q != IDLE);
    done_d = (state_q == DONE);
  end

  // Current bit; the signed rule flips the sense of the sign bit only.
  always_comb begin
    a_bit      = a_q[cnt_q];
    b_bit      = b_q[cnt_q];
    diff       = a_bit ^ b_bit;
    signed_msb = signed_q && (cnt_q == LAST);
    if (signed_msb) lt_acc_d = (a_bit & ~b_bit) | (~diff & lt_acc_q);
    else            lt_acc_d = (~a_bit & b_bit) | (~diff & lt_acc_q);
    eq_acc_d = eq_acc_q & ~diff;
  end

  // NOTE: the operand shadows are reset too; they are few flops and keep sim free of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      cnt_q     <= '0;
      lt_acc_q  <= 1'b0;
      eq_acc_q  <= 1'b1;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_mask_q <= '0;
    end else begin
      done_q <= done_d;
      unique case (state_q)
        IDLE: begin
          if (cmp.start) begin
            a_q      <= cmp.A;
            b_q      <= cmp.B;
            signed_q <= cmp.is_signed;
            cnt_q    <= '0;
            lt_acc_q <= 1'b0;
            eq_acc_q <= 1'b1;
          end
        end
        RUN: begin
          lt_acc_q <= lt_acc_d;
          eq_acc_q <= eq_acc_d;
          if (cnt_q != LAST) cnt_q <= cnt_q + cnt_t'(1);
        end
        DONE: begin
          lt_q      <= lt_acc_q;
          eq_q      <= eq_acc_q;
          gt_q      <= ~lt_acc_q & ~eq_acc_q;
          lt_mask_q <= {WIDTH{lt_acc_q}};
        end
        default: ;
      endcase
    end
  end

  assign cmp.busy    = busy_d;
  assign cmp.done    = done_q;
  assign cmp.lt      = lt_q;
  assign cmp.eq      = eq_q;
  assign cmp.gt      = gt_q;
  assign cmp.lt_mask = lt_mask_q;

endmodule : serial_lt_comparator
